// File: rtl/edge_detection_stream_multi_dir_if.sv
// edge_detection_stream_multi_dir_if: pixel-in / edge-out stream bundle
interface edge_detection_stream_multi_dir_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] in_pixel;
  logic in_valid, in_ready;
  logic out_edge, out_valid, out_ready;
  logic [3:0] out_dir;
  modport master (output in_pixel, in_valid, out_ready, input in_ready, out_edge, out_dir, out_valid);
  modport slave (input in_pixel, in_valid, out_ready, output in_ready, out_edge, out_dir, out_valid);
endinterface

// File: rtl/edge_detection_stream_multi_dir.sv
// edge_detection_stream_multi_dir: raster-stream edge detector over left/up/up-left/up-right neighbours
module edge_detection_stream_multi_dir #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic start,
  input  logic [3:0] dir_mask,
  input  logic [PIX_W-1:0] threshold,
  edge_detection_stream_multi_dir_if.slave bus,
  output logic busy,
  output logic complete
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0] mask, live, fired;
  logic [PIX_W-1:0] thr, left_px, ul_px, up_px, ur_px;
  logic [PIX_W-1:0] line_buf [IMG_W];
  logic [PIX_W-1:0] diff [4];
  logic s1_valid, advance, accept, last_px, last_out;
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a >= b ? a - b : b - a;
  endfunction
  assign advance = enb && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = state == RUN && advance;
  assign accept = bus.in_valid && bus.in_ready;
  assign last_px = row == LAST_ROW && col == LAST_COL;
  assign last_out = state == DRAIN && bus.out_valid && bus.out_ready && enb && !s1_valid;
  assign up_px = line_buf[col];
  assign ur_px = line_buf[col == LAST_COL ? col : col + 1'b1];
  assign busy = state != IDLE;
  // frame sequencing, raster position and the end-of-frame pulse; everything freezes with enb low
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      mask <= '0;
      thr <= '0;
      complete <= 1'b0;
    end else if (enb) begin
      complete <= last_out;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          mask <= dir_mask;
          thr <= threshold;
          row <= '0;
          col <= '0;
        end
        RUN: if (accept) begin
          if (last_px) state <= DRAIN;
          else if (col == LAST_COL) begin
            col <= '0;
            row <= row + 1'b1;
          end else col <= col + 1'b1;
        end
        DRAIN: if (last_out) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // one-row line buffer; the old entry is read for up/up-left before this write lands
  always_ff @(posedge clk)
    if (accept) line_buf[col] <= bus.in_pixel;
  // stage 1 occupancy
  always_ff @(posedge clk or negedge reset)
    if (!reset) s1_valid <= 1'b0;
    else if (advance) s1_valid <= accept;
  // stage 1 data: neighbour differences plus which masked neighbours exist at this position
  always_ff @(posedge clk)
    if (accept) begin
      left_px <= bus.in_pixel;
      ul_px <= up_px;
      diff[0] <= abs_diff(bus.in_pixel, left_px);
      diff[1] <= abs_diff(bus.in_pixel, up_px);
      diff[2] <= abs_diff(bus.in_pixel, ul_px);
      diff[3] <= abs_diff(bus.in_pixel, ur_px);
      live <= mask & {row != '0 && col != LAST_COL, row != '0 && col != '0, row != '0, col != '0};
    end
  // strict threshold compare per direction
  always_comb begin
    fired = '0;
    for (int i = 0; i < 4; i++) fired[i] = live[i] && diff[i] > thr;
  end
  // stage 2: registered outputs, held while the sink stalls
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_dir <= '0;
      bus.out_edge <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      bus.out_dir <= s1_valid ? fired : '0;
      bus.out_edge <= s1_valid && |fired;
    end
endmodule

// File: tb/tb_edge_detection_stream_multi_dir.sv
// tb_edge_detection_stream_multi_dir: scenario and randomized checks of the streaming edge detector on a 4x4 frame
module tb_edge_detection_stream_multi_dir;
  logic clk = 0, reset = 0, enb = 1, start = 0, busy, complete;
  logic [3:0] dir_mask = '0;
  logic [7:0] threshold = '0;
  int tests = 0, fails = 0;
  logic [7:0] img [16];
  logic [3:0] m_g;
  logic [7:0] t_g;
  edge_detection_stream_multi_dir_if #(.PIX_W(8)) bus();
  edge_detection_stream_multi_dir #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .reset(reset), .enb(enb), .start(start), .dir_mask(dir_mask),
    .threshold(threshold), .bus(bus), .busy(busy), .complete(complete));
  always #5 clk = ~clk;
  function automatic int adiff(int a, int b);
    return a > b ? a - b : b - a;
  endfunction
  function automatic logic [4:0] model(int k);
    int r = k / 4;
    int c = k % 4;
    logic [3:0] d = '0;
    if (c > 0) d[0] = adiff(img[k], img[k-1]) > int'(t_g);
    if (r > 0) d[1] = adiff(img[k], img[k-4]) > int'(t_g);
    if (r > 0 && c > 0) d[2] = adiff(img[k], img[k-5]) > int'(t_g);
    if (r > 0 && c < 3) d[3] = adiff(img[k], img[k-3]) > int'(t_g);
    d = d & m_g;
    return {|d, d};
  endfunction
  task automatic run_frame(input string name, input int stall_at, input int reset_at, input bit rnd, input bit timing, output int n_edges);
    logic [4:0] got [$];
    int idx = 0, stall = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1, ncomp = 0, comp_cyc = 0;
    n_edges = 0;
    start = 1;
    dir_mask = m_g;
    threshold = t_g;
    @(posedge clk); #1;
    start = 0;
    dir_mask = 4'($urandom);
    threshold = 8'($urandom);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
    while (cyc < 400) begin
      enb = !rnd || $urandom_range(0, 7) != 0;
      start = rnd && idx < 16 && $urandom_range(0, 3) == 0;
      bus.in_valid = idx < 16 && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_pixel = idx < 16 ? img[idx] : 8'h00;
      bus.out_ready = stall == 0 && (!rnd || $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall > 0) begin
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || (got.size() < 16 && {bus.out_edge, bus.out_dir} !== model(got.size()))) begin
          fails++;
          $display("FAIL %s stall_hold in_ready=%b out_valid=%b out=%b want in_ready=0 out_valid=1 out=%b", name, bus.in_ready, bus.out_valid, {bus.out_edge, bus.out_dir}, model(got.size() % 16));
        end
        stall--;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (bus.out_valid && bus.out_ready && enb) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got.push_back({bus.out_edge, bus.out_dir});
        if (got.size() == stall_at) stall = 5;
      end
      if (complete && enb) begin
        ncomp++;
        comp_cyc = cyc;
      end
      if (reset_at > 0 && idx == reset_at) begin
        @(posedge clk); #1 reset = 0; #1;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_edge, bus.out_dir, busy, complete} !== 9'b0) begin
          fails++;
          $display("FAIL %s reset_outputs got=%b want=0", name, {bus.in_ready, bus.out_valid, bus.out_edge, bus.out_dir, busy, complete});
        end
        @(posedge clk); #1 reset = 1;
        enb = 1;
        return;
      end
      if (ncomp > 0 && cyc >= comp_cyc + 3) break;
      @(posedge clk); #1;
      cyc++;
    end
    enb = 1;
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    tests++;
    if (cyc >= 400) begin fails++; $display("FAIL %s timeout cycles=%0d limit=400", name, cyc); end
    tests++;
    if (got.size() != 16) begin fails++; $display("FAIL %s output_count got=%0d want=16", name, got.size()); end
    tests++;
    if (ncomp != 1) begin fails++; $display("FAIL %s complete_pulses got=%0d want=1", name, ncomp); end
    if (timing) begin
      tests++;
      if (first_out != first_acc + 2) begin fails++; $display("FAIL %s latency first_out=%0d want=%0d", name, first_out, first_acc + 2); end
      tests++;
      if (comp_cyc != last_out + 1) begin fails++; $display("FAIL %s complete_timing got=%0d want=%0d", name, comp_cyc, last_out + 1); end
    end
    foreach (got[k]) if (k < 16) begin
      n_edges += int'(got[k][4]);
      tests++;
      if (got[k] !== model(k)) begin fails++; $display("FAIL %s pixel%0d edge_dir got=%b want=%b", name, k, got[k], model(k)); end
    end
  endtask
  task automatic test_reset;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_edge, bus.out_dir, busy, complete} !== 9'b0) begin
      fails++;
      $display("FAIL reset_state got=%b want=0", {bus.in_ready, bus.out_valid, bus.out_edge, bus.out_dir, busy, complete});
    end
  endtask
  task automatic test_uniform;
    int ne;
    foreach (img[k]) img[k] = 8'd10;
    m_g = 4'b1111;
    t_g = 8'd5;
    run_frame("uniform", 0, 0, 0, 1, ne);
    tests++;
    if (ne != 0) begin fails++; $display("FAIL uniform edges got=%0d want=0", ne); end
  endtask
  task automatic test_columns;
    int ne;
    foreach (img[k]) img[k] = k % 4 >= 2 ? 8'd100 : 8'd0;
    t_g = 8'd50;
    m_g = 4'b0001;
    run_frame("columns_left", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 4) begin fails++; $display("FAIL columns_left edges got=%0d want=4", ne); end
    m_g = 4'b0010;
    run_frame("columns_up", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 0) begin fails++; $display("FAIL columns_up edges got=%0d want=0", ne); end
  endtask
  task automatic test_rows;
    int ne;
    foreach (img[k]) img[k] = k / 4 >= 2 ? 8'd200 : 8'd0;
    m_g = 4'b1111;
    t_g = 8'd50;
    run_frame("rows", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 4) begin fails++; $display("FAIL rows edges got=%0d want=4", ne); end
  endtask
  task automatic test_threshold;
    int ne;
    foreach (img[k]) img[k] = k % 2 == 1 ? 8'd50 : 8'd0;
    m_g = 4'b0001;
    t_g = 8'd50;
    run_frame("thr50", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 0) begin fails++; $display("FAIL thr50 edges got=%0d want=0", ne); end
    t_g = 8'd49;
    run_frame("thr49", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 12) begin fails++; $display("FAIL thr49 edges got=%0d want=12", ne); end
  endtask
  task automatic test_backpressure;
    int ne;
    foreach (img[k]) img[k] = k % 4 >= 2 ? 8'd100 : 8'd0;
    m_g = 4'b0001;
    t_g = 8'd50;
    run_frame("backpressure", 6, 0, 0, 0, ne);
    tests++;
    if (ne != 4) begin fails++; $display("FAIL backpressure edges got=%0d want=4", ne); end
  endtask
  task automatic test_reset_midframe;
    int ne;
    foreach (img[k]) img[k] = 8'(200 + $urandom_range(0, 55));
    m_g = 4'b1111;
    t_g = 8'd0;
    run_frame("partial", 0, 7, 0, 0, ne);
    foreach (img[k]) img[k] = k % 4 >= 2 ? 8'd100 : 8'd0;
    m_g = 4'b0001;
    t_g = 8'd50;
    run_frame("after_reset", 0, 0, 0, 0, ne);
    tests++;
    if (ne != 4) begin fails++; $display("FAIL after_reset edges got=%0d want=4", ne); end
    m_g = 4'b1111;
    run_frame("after_reset_all", 0, 0, 0, 0, ne);
  endtask
  task automatic test_random;
    int ne;
    for (int f = 0; f < 8; f++) begin
      foreach (img[k]) img[k] = 8'($urandom_range(0, f % 2 == 1 ? 255 : 60));
      m_g = 4'($urandom);
      t_g = 8'($urandom_range(0, f % 2 == 1 ? 200 : 40));
      run_frame($sformatf("random%0d", f), 0, 0, 1, 0, ne);
    end
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_pixel = '0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1;
    @(posedge clk); #1;
    test_uniform;
    test_columns;
    test_rows;
    test_threshold;
    test_backpressure;
    test_reset_midframe;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
